rho_lane_sched: RTL and testbench

- Controller that time-shares one 16-angle rho parameter datapath between the left-ROI and right-ROI edge-point streams.
- Per frame it performs two passes, LEFT first and then RIGHT. Each pass feeds exactly PTS points to the datapath with interest_part held constant, then waits for the datapath result.
- Captures phase/rho per side and emits one paired lane result per frame to the lane-drawing stage.

---
 rtl/rho_lane_sched_pkg.sv | 35 +++
 rtl/rho_lane_sched_feeder.sv | 67 ++++++
 rtl/rho_lane_sched.sv | 148 ++++++++++++++
 tb/tb_rho_lane_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rho_lane_sched_pkg.sv
// Shared encodings and defaults for the two-pass left/right rho lane scheduler.
package rho_lane_sched_pkg;

  localparam int PTS_DEF   = 256;
  localparam int RHO_W_DEF = 28;
  localparam int TMO_DEF   = 1023;

  localparam int XY_W    = 24;
  localparam int PHASE_W = 8;

  localparam int AXIS_X_MSB = 23;
  localparam int AXIS_X_LSB = 12;
  localparam int AXIS_Y_MSB = 11;
  localparam int AXIS_Y_LSB = 0;

  localparam int ERR_TMO = 0;
  localparam int ERR_OVR = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FEED_L = 3'd1;
  localparam logic [2:0] ST_WAIT_L = 3'd2;
  localparam logic [2:0] ST_FEED_R = 3'd3;
  localparam logic [2:0] ST_WAIT_R = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FEED_L = ST_FEED_L,
    WAIT_L = ST_WAIT_L,
    FEED_R = ST_FEED_R,
    WAIT_R = ST_WAIT_R,
    DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/rho_lane_sched_feeder.sv
// Per-pass point feeder: counts exactly PTS datapath strobes, zero-padding after an early last.
module rho_pass_feeder
  import rho_lane_sched_pkg::*;
#(
  parameter int PTS = PTS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            active,
  input  logic            pt_vld,
  input  logic [XY_W-1:0] pt_xy,
  input  logic            pt_last,
  output logic            pt_rdy,
  output logic            dp_in_vld,
  output logic [XY_W-1:0] dp_xy,
  output logic            full
);

  localparam int            CW    = $clog2(PTS + 1);
  localparam logic [CW-1:0] PTS_C = CW'(PTS);

  logic [CW-1:0]   cnt;
  logic            pad;
  logic            hs;
  logic            vld_p0;
  logic [XY_W-1:0] dp_xy_p0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == PTS_C) ? v : v + 1'b1;
  endfunction

  assign full   = (cnt == PTS_C);
  assign pt_rdy = active && !pad && !full;
  assign hs     = pt_vld && pt_rdy;

  // p0: one-cycle registered point strobe towards the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pad      <= 1'b0;
      vld_p0   <= 1'b0;
      dp_xy_p0 <= '0;
    end else if (!active) begin
      cnt    <= '0;
      pad    <= 1'b0;
      vld_p0 <= 1'b0;
    end else if (hs) begin
      vld_p0                             <= 1'b1;
      dp_xy_p0[AXIS_X_MSB:AXIS_X_LSB]    <= pt_xy[AXIS_X_MSB:AXIS_X_LSB];
      dp_xy_p0[AXIS_Y_MSB:AXIS_Y_LSB]    <= pt_xy[AXIS_Y_MSB:AXIS_Y_LSB];
      cnt                                <= sat_inc(cnt);
      // a last on the final slot needs no padding
      if (pt_last && (cnt != PTS_C - 1'b1))
        pad <= 1'b1;
    end else if (pad && !full) begin
      vld_p0   <= 1'b1;
      dp_xy_p0 <= '0;
      cnt      <= sat_inc(cnt);
    end else begin
      vld_p0 <= 1'b0;
    end
  end

  assign dp_in_vld = vld_p0;
  assign dp_xy     = dp_xy_p0;

endmodule

// File: rtl/rho_lane_sched.sv
// Time-shares one rho datapath between left and right ROI streams; one paired lane result per frame.
module rho_lane_sched
  import rho_lane_sched_pkg::*;
#(
  parameter int PTS   = PTS_DEF,
  parameter int RHO_W = RHO_W_DEF,
  parameter int TMO   = TMO_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               l_vld,
  input  logic [XY_W-1:0]    l_xy,
  input  logic               l_last,
  output logic               l_rdy,
  input  logic               r_vld,
  input  logic [XY_W-1:0]    r_xy,
  input  logic               r_last,
  output logic               r_rdy,
  output logic               dp_in_vld,
  output logic [XY_W-1:0]    dp_xy,
  output logic               dp_part,
  input  logic               dp_out_vld,
  input  logic [PHASE_W-1:0] dp_phase,
  input  logic [RHO_W-1:0]   dp_rho,
  output logic               res_vld,
  output logic [PHASE_W-1:0] l_phase,
  output logic [PHASE_W-1:0] r_phase,
  output logic [RHO_W-1:0]   l_rho,
  output logic [RHO_W-1:0]   r_rho,
  output logic               busy,
  output logic [1:0]         err
);

  localparam int            WW    = $clog2(TMO + 1);
  localparam logic [WW-1:0] TMO_C = WW'(TMO);

  state_t          state, nxt;
  logic [WW-1:0]   wcnt;
  logic            feed, side_r, in_wait, tmo_hit, wait_hit, accept;
  logic            f_vld, f_last, f_rdy, f_full;
  logic [XY_W-1:0] f_xy;

  assign feed     = (state == FEED_L) || (state == FEED_R);
  assign side_r   = (state == FEED_R);
  assign in_wait  = (state == WAIT_L) || (state == WAIT_R);
  assign tmo_hit  = in_wait && !dp_out_vld && (wcnt == TMO_C);
  assign wait_hit = dp_out_vld || tmo_hit;
  assign accept   = (state == IDLE) && frame_start;

  assign f_vld  = side_r ? r_vld  : l_vld;
  assign f_xy   = side_r ? r_xy   : l_xy;
  assign f_last = side_r ? r_last : l_last;
  assign l_rdy  = (state == FEED_L) && f_rdy;
  assign r_rdy  = side_r && f_rdy;

  rho_pass_feeder #(.PTS(PTS)) u_feeder (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (feed),
    .pt_vld    (f_vld),
    .pt_xy     (f_xy),
    .pt_last   (f_last),
    .pt_rdy    (f_rdy),
    .dp_in_vld (dp_in_vld),
    .dp_xy     (dp_xy),
    .full      (f_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    busy    = 1'b1;
    res_vld = 1'b0;
    dp_part = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_start) nxt = FEED_L;
      end
      FEED_L: if (f_full) nxt = WAIT_L;
      WAIT_L: if (wait_hit) nxt = FEED_R;
      FEED_R: begin
        dp_part = 1'b1;
        if (f_full) nxt = WAIT_R;
      end
      WAIT_R: begin
        dp_part = 1'b1;
        if (wait_hit) nxt = DONE;
      end
      DONE: begin
        dp_part = 1'b1;
        res_vld = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wcnt <= '0;
    else if (in_wait && !wait_hit) wcnt <= wcnt + 1'b1;
    else                       wcnt <= '0;
  end

  // capture stage: a result and a timeout on the same cycle resolve in favour of the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_phase <= '0;
      l_rho   <= '0;
      r_phase <= '0;
      r_rho   <= '0;
      err     <= '0;
    end else begin
      if (accept)
        err <= '0;
      else if (frame_start)
        err[ERR_OVR] <= 1'b1;

      if (state == WAIT_L) begin
        if (dp_out_vld) begin
          l_phase <= dp_phase;
          l_rho   <= dp_rho;
        end else if (tmo_hit) begin
          l_phase      <= '0;
          l_rho        <= '0;
          err[ERR_TMO] <= 1'b1;
        end
      end

      if (state == WAIT_R) begin
        if (dp_out_vld) begin
          r_phase <= dp_phase;
          r_rho   <= dp_rho;
        end else if (tmo_hit) begin
          r_phase      <= '0;
          r_rho        <= '0;
          err[ERR_TMO] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rho_lane_sched.sv
// Directed bench for rho_lane_sched: expected point streams and paired results come from a queue model.
module tb_rho_lane_sched;

  localparam int PTS = 256;
  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        l_vld = 1'b0, l_last = 1'b0, r_vld = 1'b0, r_last = 1'b0;
  logic [23:0] l_xy = '0, r_xy = '0;
  logic        l_rdy, r_rdy, dp_in_vld, dp_part, res_vld, busy;
  logic [23:0] dp_xy;
  logic        dp_out_vld;
  logic [7:0]  dp_phase, l_phase, r_phase;
  logic [27:0] dp_rho, l_rho, r_rho;
  logic [1:0]  err;

  rho_lane_sched dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .l_vld(l_vld), .l_xy(l_xy), .l_last(l_last), .l_rdy(l_rdy),
    .r_vld(r_vld), .r_xy(r_xy), .r_last(r_last), .r_rdy(r_rdy),
    .dp_in_vld(dp_in_vld), .dp_xy(dp_xy), .dp_part(dp_part),
    .dp_out_vld(dp_out_vld), .dp_phase(dp_phase), .dp_rho(dp_rho),
    .res_vld(res_vld), .l_phase(l_phase), .r_phase(r_phase),
    .l_rho(l_rho), .r_rho(r_rho), .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  int          n_vec = 0, n_bad = 0;
  logic [24:0] exp_q[$];
  int          n_dp[2], n_zero[2];
  int          n_tog = 0, res_cnt = 0, r0 = 0;
  longint      cyc = 0, last_dp_cyc = 0, res_cyc = 0;
  bit          abort = 1'b0;
  logic [7:0]  exp_lp, exp_rp;
  logic [27:0] exp_lr, exp_rr;
  logic [1:0]  exp_err;
  bit          resp_en[2];
  logic [7:0]  resp_ph[2];
  logic [27:0] resp_rho[2];
  bit          spur = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pt(input bit side, input int i);
    logic [11:0] x, y;
    x = (side ? 12'h800 : 12'h100) + 12'(i);
    y = 12'(3 * i + 1);
    return {x, y};
  endfunction

  // Datapath stand-in: answers a fixed delay after every PTS-th strobe
  initial begin
    int  dp_cnt;
    int  dp_wait;
    bit  resp_side;
    dp_cnt = 0; dp_wait = -1; resp_side = 1'b0;
    dp_out_vld = 1'b0; dp_phase = '0; dp_rho = '0;
    forever begin
      @(posedge clk); #1;
      dp_out_vld = 1'b0;
      if (!rst_n) begin
        dp_cnt = 0; dp_wait = -1;
      end else begin
        if (spur) begin
          spur = 1'b0; dp_out_vld = 1'b1; dp_phase = 8'h99; dp_rho = 28'd9;
        end
        if (dp_wait > 0) dp_wait--;
        else if (dp_wait == 0) begin
          dp_wait = -1;
          if (resp_en[resp_side]) begin
            dp_out_vld = 1'b1; dp_phase = resp_ph[resp_side]; dp_rho = resp_rho[resp_side];
          end
        end
        if (dp_in_vld) begin
          dp_cnt++;
          if (dp_cnt == PTS) begin
            dp_cnt = 0; resp_side = dp_part; dp_wait = 5;
          end
        end
      end
    end
  end

  // Compare process: every datapath strobe and every paired result
  initial begin
    logic        prev_part;
    logic [24:0] e;
    prev_part = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (dp_in_vld) begin
          n_dp[dp_part]++;
          if (dp_xy == 24'h0) n_zero[dp_part]++;
          last_dp_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL dp_extra: got part %0d xy 0x%0h, required no strobe", dp_part, dp_xy);
          end else begin
            e = exp_q.pop_front();
            chk("dp_stream", 64'({dp_part, dp_xy}), 64'(e));
          end
        end
        chk("rdy_excl", 64'(l_rdy & r_rdy), 64'd0);
        if (l_rdy) chk("l_rdy_part", 64'(dp_part), 64'd0);
        if (r_rdy) chk("r_rdy_part", 64'(dp_part), 64'd1);
        if (busy && (dp_part != prev_part)) n_tog++;
        if (res_vld) begin
          res_cnt++;
          res_cyc = cyc;
          chk("l_phase", 64'(l_phase), 64'(exp_lp));
          chk("l_rho",   64'(l_rho),   64'(exp_lr));
          chk("r_phase", 64'(r_phase), 64'(exp_rp));
          chk("r_rho",   64'(r_rho),   64'(exp_rr));
          chk("res_err", 64'(err),     64'(exp_err));
        end
      end
      prev_part = dp_part;
    end
  end

  task automatic send_pt(input bit side, input logic [23:0] xy, input bit last);
    bit hs, ok;
    if (abort) return;
    if (side) begin r_vld = 1'b1; r_xy = xy; r_last = last; end
    else      begin l_vld = 1'b1; l_xy = xy; l_last = last; end
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk); hs = side ? r_rdy : l_rdy;
      @(posedge clk); #1;
      ok = hs;
    end
    if (side) begin r_vld = 1'b0; r_last = 1'b0; end
    else      begin l_vld = 1'b0; l_last = 1'b0; end
    chk("handshake", 64'(ok), 64'd1);
    if (!ok) abort = 1'b1;
  endtask

  task automatic send_pass(input bit side, input int n, input int last_idx,
                           input bit gaps, input int ovr_at);
    for (int i = 0; i < n; i++) begin
      if (abort) return;
      if (gaps && ($urandom_range(0, 1) == 1)) begin @(posedge clk); #1; end
      if (i == ovr_at) begin frame_start = 1'b1; @(posedge clk); #1; frame_start = 1'b0; end
      exp_q.push_back({side, pt(side, i)});
      send_pt(side, pt(side, i), i == last_idx);
      if (i == last_idx) begin
        for (int k = i + 1; k < PTS; k++) exp_q.push_back({side, 24'h0});
        return;
      end
    end
  endtask

  task automatic hold_block(input bit side);
    int hi;
    hi = 0;
    if (side) begin r_vld = 1'b1; r_xy = 24'hFFFFFF; end
    else      begin l_vld = 1'b1; l_xy = 24'hFFFFFF; end
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (side ? r_rdy : l_rdy) hi++;
    end
    @(posedge clk); #1;
    if (side) r_vld = 1'b0; else l_vld = 1'b0;
    chk("blocked_rdy", 64'(hi), 64'd0);
  endtask

  task automatic set_resp(input logic [7:0] lp, input logic [27:0] lr,
                          input logic [7:0] rp, input logic [27:0] rr);
    resp_ph[0] = lp; resp_rho[0] = lr; resp_ph[1] = rp; resp_rho[1] = rr;
  endtask

  task automatic begin_frame(input logic [7:0] lp, input logic [27:0] lr,
                             input logic [7:0] rp, input logic [27:0] rr, input logic [1:0] e);
    exp_lp = lp; exp_lr = lr; exp_rp = rp; exp_rr = rr; exp_err = e;
    n_dp = '{0, 0}; n_zero = '{0, 0}; n_tog = 0; r0 = res_cnt;
    frame_start = 1'b1; @(posedge clk); #1; frame_start = 1'b0;
    chk("busy_on_start", 64'(busy), 64'd1);
    chk("err_cleared", 64'(err), 64'd0);
  endtask

  task automatic end_frame(input bit done_ovr, input int zl);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin @(negedge clk); got = res_vld; end
    chk("res_seen", 64'(got), 64'd1);
    if (done_ovr) frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("busy_after", 64'(busy), 64'd0);
    chk("part_idle",  64'(dp_part), 64'd0);
    chk("res_pulses", 64'(res_cnt - r0), 64'd1);
    chk("n_dp_left",  64'(n_dp[0]), 64'd256);
    chk("n_dp_right", 64'(n_dp[1]), 64'd256);
    chk("n_pad_left", 64'(n_zero[0]), 64'(zl));
    chk("part_toggles", 64'(n_tog), 64'd1);
    chk("q_drained",  64'(exp_q.size()), 64'd0);
    if (done_ovr) chk("err_done_ovr", 64'(err), 64'(exp_err | 2'b10));
  endtask

  initial begin
    longint gap;
    resp_en = '{1'b1, 1'b1};
    set_resp(8'd30, 28'd500, 8'd150, 28'd700);
    n_dp = '{0, 0}; n_zero = '{0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({dp_in_vld, dp_part, l_rdy, r_rdy, res_vld, busy, err, dp_xy}), 64'd0);
    chk("rst_cap", 64'({l_phase, r_phase, l_rho}), 64'd0);
    chk("rst_rrho", 64'(r_rho), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // contiguous left and right passes
    begin_frame(8'd30, 28'd500, 8'd150, 28'd700, 2'b00);
    send_pass(1'b0, PTS, -1, 1'b0, -1);
    hold_block(1'b0);
    send_pass(1'b1, PTS, -1, 1'b0, -1);
    end_frame(1'b0, 0);

    // a result strobe while idle must not disturb the captured pair
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_l_phase", 64'(l_phase), 64'd30);
    chk("spur_r_rho",   64'(r_rho),   64'd700);

    // left stream ends early on point 100
    set_resp(8'd45, 28'd1234, 8'd200, 28'd99);
    begin_frame(8'd45, 28'd1234, 8'd200, 28'd99, 2'b00);
    send_pass(1'b0, PTS, 99, 1'b0, -1);
    hold_block(1'b0);
    send_pass(1'b1, PTS, -1, 1'b0, -1);
    end_frame(1'b0, 156);

    // bursty left stream, extreme result values
    set_resp(8'd12, 28'd4095, 8'd255, 28'hFFFFFFF);
    begin_frame(8'd12, 28'd4095, 8'd255, 28'hFFFFFFF, 2'b00);
    send_pass(1'b0, PTS, -1, 1'b1, -1);
    send_pass(1'b1, PTS, -1, 1'b1, -1);
    end_frame(1'b0, 0);

    // right pass never answered; frame_start lands in the DONE cycle
    set_resp(8'd1, 28'd1, 8'd77, 28'd77);
    resp_en[1] = 1'b0;
    begin_frame(8'd1, 28'd1, 8'd0, 28'd0, 2'b01);
    send_pass(1'b0, PTS, -1, 1'b0, -1);
    send_pass(1'b1, PTS, -1, 1'b0, -1);
    end_frame(1'b1, 0);
    gap = res_cyc - last_dp_cyc;
    n_vec++;
    if (gap < TMO + 1 || gap > TMO + 2) begin
      n_bad++;
      $display("FAIL tmo_latency: got %0d cycles, required %0d..%0d", gap, TMO + 1, TMO + 2);
    end
    resp_en[1] = 1'b1;

    // frame_start reissued mid right pass
    set_resp(8'd77, 28'd3333, 8'd5, 28'd65535);
    begin_frame(8'd77, 28'd3333, 8'd5, 28'd65535, 2'b10);
    send_pass(1'b0, PTS, -1, 1'b0, -1);
    send_pass(1'b1, PTS, -1, 1'b0, 40);
    end_frame(1'b0, 0);

    // reset at point 77 of the left pass
    begin_frame(8'd0, 28'd0, 8'd0, 28'd0, 2'b00);
    send_pass(1'b0, 77, -1, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 64'({dp_in_vld, dp_part, l_rdy, r_rdy, res_vld, busy, err, dp_xy}), 64'd0);
    chk("mid_rst_cap", 64'({l_phase, r_phase, l_rho}), 64'd0);
    chk("mid_rst_rrho", 64'(r_rho), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_resp(8'd30, 28'd500, 8'd150, 28'd700);
    begin_frame(8'd30, 28'd500, 8'd150, 28'd700, 2'b00);
    send_pass(1'b0, PTS, -1, 1'b0, -1);
    send_pass(1'b1, PTS, -1, 1'b0, -1);
    end_frame(1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
